// File: rtl/row_buff_pingpong.sv
// row_buff_pingpong: ping-pong assembler that packs ROW_SIZE-element rows into COLUMN_SIZE-row matrices
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input row handshake; dats = row (element 0 at LSBs)
//   dend                accepted row closes the matrix; flush closes a partial matrix without data
//   out_valid/out_ready output matrix handshake
//   datsOut             row r at [(r+1)*ROW_W-1 : r*ROW_W]; out_rows = valid rows; out_short = out_rows < COLUMN_SIZE
module row_buff_pingpong #(
    parameter int DATA_SIZE   = 16,
    parameter int ROW_SIZE    = 64,
    parameter int COLUMN_SIZE = 64,
    localparam int ROW_W = DATA_SIZE * ROW_SIZE,
    localparam int MAT_W = ROW_W * COLUMN_SIZE,
    localparam int CNT_W = $clog2(COLUMN_SIZE + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] dats,
    input  logic             dend,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAT_W-1:0] datsOut,
    output logic [CNT_W-1:0] out_rows,
    output logic             out_short
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    logic [MAT_W-1:0] r_bank [2];
    state_t           r_st   [2];
    logic [CNT_W-1:0] r_cnt  [2];
    logic             r_fill;
    logic             r_out_sel;
    logic [CNT_W-1:0] r_wr_row;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [MAT_W-1:0] r_dats_out;
    logic [CNT_W-1:0] r_out_rows;
    logic             r_out_short;

    logic [MAT_W-1:0] w_bank_n [2];
    state_t           w_st_n   [2];
    logic [CNT_W-1:0] w_cnt_n  [2];
    logic             w_acc;
    logic             w_close;
    logic             w_xfer;
    logic             w_other;
    logic             w_fill_n;
    logic [CNT_W-1:0] w_rows;

    assign w_acc    = in_valid & r_in_ready;
    assign w_xfer   = r_out_valid & out_ready;
    assign w_other  = ~r_out_sel;
    assign w_rows   = r_wr_row + CNT_W'(w_acc);
    // a flush with no row pending is ignored; wr_row>0 implies the fill bank is FILLING
    assign w_close  = w_acc ? (dend | flush | (r_wr_row == CNT_W'(COLUMN_SIZE - 1)))
                            : (flush & (r_wr_row != '0));
    assign w_fill_n = r_fill ^ w_close;

    // next bank image: write/close on the fill bank, clear on the presented bank;
    // the two never coincide because a fill bank can only be FULL when no row is accepted
    always_comb begin
        w_bank_n = r_bank;
        w_st_n   = r_st;
        w_cnt_n  = r_cnt;
        for (int r = 0; r < COLUMN_SIZE; r++)
            if (w_acc && r_wr_row == CNT_W'(r))
                w_bank_n[r_fill][r*ROW_W +: ROW_W] = dats;
        if (w_acc)
            w_st_n[r_fill] = FILLING;
        if (w_close) begin
            w_st_n[r_fill]  = FULL;
            w_cnt_n[r_fill] = w_rows;
        end
        if (w_xfer) begin
            w_bank_n[r_out_sel] = '0;
            w_st_n[r_out_sel]   = EMPTY;
            w_cnt_n[r_out_sel]  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bank      <= '{default: '0};
            r_st        <= '{default: EMPTY};
            r_cnt       <= '{default: '0};
            r_fill      <= 1'b0;
            r_out_sel   <= 1'b0;
            r_wr_row    <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_dats_out  <= '0;
            r_out_rows  <= '0;
            r_out_short <= 1'b0;
        end else begin
            r_bank     <= w_bank_n;
            r_st       <= w_st_n;
            r_cnt      <= w_cnt_n;
            r_fill     <= w_fill_n;
            r_wr_row   <= w_close ? '0 : w_rows;
            r_in_ready <= w_st_n[w_fill_n] != FULL;
            // on a transfer the other bank is taken from its next image so a matrix
            // closing on the same edge is presented without an out_valid bubble
            if (w_xfer) begin
                r_out_sel   <= w_other;
                r_out_valid <= w_st_n[w_other] == FULL;
                if (w_st_n[w_other] == FULL) begin
                    r_dats_out  <= w_bank_n[w_other];
                    r_out_rows  <= w_cnt_n[w_other];
                    r_out_short <= w_cnt_n[w_other] < CNT_W'(COLUMN_SIZE);
                end
            end else if (!r_out_valid && r_st[r_out_sel] == FULL) begin
                r_out_valid <= 1'b1;
                r_dats_out  <= r_bank[r_out_sel];
                r_out_rows  <= r_cnt[r_out_sel];
                r_out_short <= r_cnt[r_out_sel] < CNT_W'(COLUMN_SIZE);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign datsOut   = r_dats_out;
    assign out_rows  = r_out_rows;
    assign out_short = r_out_short;
endmodule

// File: tb/tb_row_buff_pingpong.sv
// tb_row_buff_pingpong: directed bench for row_buff_pingpong with DATA_SIZE=4, ROW_SIZE=2, COLUMN_SIZE=4
module tb_row_buff_pingpong;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  dats;
    logic        dend;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] datsOut;
    logic [2:0]  out_rows;
    logic        out_short;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc;

    row_buff_pingpong #(.DATA_SIZE(4), .ROW_SIZE(2), .COLUMN_SIZE(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dats(dats), .dend(dend), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .datsOut(datsOut), .out_rows(out_rows), .out_short(out_short)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] mat, input logic [2:0] rows, input logic sh);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, datsOut, mat);
        chk({tag, "_rows"}, {29'd0, out_rows}, {29'd0, rows});
        chk({tag, "_short"}, {31'd0, out_short}, {31'd0, sh});
    endtask

    initial begin
        logic [7:0] tbl [8];
        reset = 1'b1; in_valid = 1'b0; dats = '0; dend = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_dats_out", datsOut, 32'd0);
        chk("rst_out_rows", {29'd0, out_rows}, 32'd0);
        chk("rst_out_short", {31'd0, out_short}, 32'd0);
        tick(); tick();
        chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // full matrix
        in_valid = 1'b1;
        dats = 8'h10; tick();
        dats = 8'h32; tick();
        dats = 8'h54; tick();
        dats = 8'h76; tick();
        in_valid = 1'b0;
        chk("full_not_yet_valid", {31'd0, out_valid}, 32'd0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("full", 32'h76543210, 3'd4, 1'b0);
        tick();
        chk("full_taken", {31'd0, out_valid}, 32'd0);
        chk("full_hold_data", datsOut, 32'h76543210);

        // short matrix via dend
        in_valid = 1'b1;
        dats = 8'hA1; tick();
        dats = 8'hB2; dend = 1'b1; tick();
        in_valid = 1'b0; dend = 1'b0;
        tick();
        chk_out("short", 32'h0000B2A1, 3'd2, 1'b1);
        tick();
        chk("short_taken", {31'd0, out_valid}, 32'd0);

        // flush
        in_valid = 1'b1; dats = 8'hC3; tick();
        in_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; tick();
        chk_out("flush", 32'h000000C3, 3'd1, 1'b1);
        tick();
        flush = 1'b1; tick();
        flush = 1'b0; tick(); tick();
        chk("empty_flush_no_valid", {31'd0, out_valid}, 32'd0);
        chk("empty_flush_in_ready", {31'd0, in_ready}, 32'd1);

        // backpressure: 12 rows offered, only 8 fit while the consumer stalls
        out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            dats = 8'(8'h81 + n_acc);
            if (in_ready) n_acc++;
            tick();
        end
        chk("bp_accepted", n_acc, 32'd8);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk_out("bp_m1_stall", 32'h84838281, 3'd4, 1'b0);
        tick();
        chk("bp_m1_stable", datsOut, 32'h84838281);
        chk("bp_no_extra_row", {31'd0, in_ready}, 32'd0);
        dats = 8'h89; out_ready = 1'b1;
        tick();
        chk_out("bp_m2", 32'h88878685, 3'd4, 1'b0);
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            dats = 8'(8'h89 + i);
            tick();
            chk("bp_rows9_12_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk_out("bp_m3", 32'h8C8B8A89, 3'd4, 1'b0);
        tick();
        chk("bp_m3_taken", {31'd0, out_valid}, 32'd0);

        // second matrix closes on the edge the first is taken
        tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dats = tbl[i];
            out_ready = (i == 7);
            tick();
            chk("same_edge_in_ready", {31'd0, in_ready}, 32'd1);
            if (i == 6) chk_out("same_edge_a", 32'h44332211, 3'd4, 1'b0);
        end
        chk_out("same_edge_b", 32'h88776655, 3'd4, 1'b0);

        // reset mid-fill while a matrix is pending
        out_ready = 1'b0; dats = 8'h99;
        tick();
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_dats_out", datsOut, 32'd0);
        chk("mid_rst_out_rows", {29'd0, out_rows}, 32'd0);
        chk("mid_rst_out_short", {31'd0, out_short}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1; in_valid = 1'b1;
        dats = 8'h5A; tick();
        dats = 8'h6B; dend = 1'b1; tick();
        in_valid = 1'b0; dend = 1'b0;
        tick();
        chk_out("after_rst", 32'h00006B5A, 3'd2, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
